onchip_memory_dp_pipe: RTL and testbench

ONCHIP_MEMORY_DP_PIPE -- requirements
Module: onchip_memory_dp_pipe

---
 rtl/onchip_mem_pkg.sv | 17 +
 rtl/onchip_mem_ram_core.sv | 59 +++++
 rtl/onchip_memory_dp_pipe.sv | 158 +++++++++++++++
 tb/tb_onchip_memory_dp_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the dual-port on-chip memory: read-latency limits,
// byte-lane helper and the collision-arbitration winner encoding.
package onchip_mem_pkg;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        WIN_S1 = 1'b0,
        WIN_S2 = 1'b1
    } win_e;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/onchip_mem_ram_core.sv
// True dual-port byte-enabled storage with old-data read-during-write and a
// single registered read stage per port; out-of-range reads are zeroed by request.
module onchip_mem_ram_core
    import onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8192,
    parameter     INIT_FILE  = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_rd,
    input  logic                       a_we,
    input  logic [$clog2(DEPTH)-1:0]   a_idx,
    input  logic [DATA_WIDTH/8-1:0]    a_be,
    input  logic [DATA_WIDTH-1:0]      a_wdata,
    input  logic                       a_zero,
    output logic [DATA_WIDTH-1:0]      a_q,
    input  logic                       b_rd,
    input  logic                       b_we,
    input  logic [$clog2(DEPTH)-1:0]   b_idx,
    input  logic [DATA_WIDTH/8-1:0]    b_be,
    input  logic [DATA_WIDTH-1:0]      b_wdata,
    input  logic                       b_zero,
    output logic [DATA_WIDTH-1:0]      b_q
);

    localparam int LANES = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Byte-lane writes; the top guarantees the two ports never hit one word together.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (a_we && a_be[i]) begin
                mem_r[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
            end
            if (b_we && b_be[i]) begin
                mem_r[b_idx][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
    end

    // Registered read stage; samples the pre-write contents of the addressed word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_rd) begin
                a_q <= a_zero ? '0 : mem_r[a_idx];
            end
            if (b_rd) begin
                b_q <= b_zero ? '0 : mem_r[b_idx];
            end
        end
    end

endmodule

// File: rtl/onchip_memory_dp_pipe.sv
// Dual-port pipelined on-chip memory: clock-enable freeze, write-collision
// arbitration with alternating fairness, range checking and 1- or 2-cycle reads.
module onchip_memory_dp_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 8192,
    parameter int READ_LATENCY = 1,
    parameter     INIT_FILE    = ""
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clken,
    input  logic                     reset_req,
    input  logic [ADDR_WIDTH-1:0]    s1_address,
    input  logic                     s1_chipselect,
    input  logic                     s1_read,
    input  logic                     s1_write,
    input  logic [DATA_WIDTH/8-1:0]  s1_byteenable,
    input  logic [DATA_WIDTH-1:0]    s1_writedata,
    output logic [DATA_WIDTH-1:0]    s1_readdata,
    output logic                     s1_readdatavalid,
    output logic                     s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]    s2_address,
    input  logic                     s2_chipselect,
    input  logic                     s2_read,
    input  logic                     s2_write,
    input  logic [DATA_WIDTH/8-1:0]  s2_byteenable,
    input  logic [DATA_WIDTH-1:0]    s2_writedata,
    output logic [DATA_WIDTH-1:0]    s2_readdata,
    output logic                     s2_readdatavalid,
    output logic                     s2_waitrequest,
    output logic                     err_oob
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_chk_dw
        $error("onchip_memory_dp_pipe: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30 || DEPTH < 2 || DEPTH > (64'd1 << ADDR_WIDTH)) begin : g_chk_depth
        $error("onchip_memory_dp_pipe: DEPTH must be in 2..2**ADDR_WIDTH");
    end
    if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_chk_lat
        $error("onchip_memory_dp_pipe: READ_LATENCY must be 1 or 2");
    end

    logic                  en_s;
    logic                  s1_wr_s, s2_wr_s, s1_rd_s, s2_rd_s;
    logic                  s1_inr_s, s2_inr_s, s1_we_s, s2_we_s;
    logic                  collide_s, oob_hit_s;
    win_e                  win_s;
    logic                  s2_lost_r, err_oob_r;
    logic                  s1_v1_r, s2_v1_r;
    logic [DATA_WIDTH-1:0] s1_q_s, s2_q_s;

    // Request decode, range check and collision arbitration.
    always_comb begin
        en_s      = clken & ~reset_req;
        s1_wr_s   = s1_chipselect & s1_write & en_s;
        s2_wr_s   = s2_chipselect & s2_write & en_s;
        s1_rd_s   = s1_chipselect & s1_read & ~s1_write & en_s;
        s2_rd_s   = s2_chipselect & s2_read & ~s2_write & en_s;
        s1_inr_s  = ({1'b0, s1_address} < DEPTH_LIM);
        s2_inr_s  = ({1'b0, s2_address} < DEPTH_LIM);
        collide_s = s1_wr_s & s2_wr_s & (s1_address == s2_address);
        win_s     = WIN_S1;
        // s2 takes its turn only right after losing, so neither side waits twice in a row.
        if (collide_s && s2_lost_r) begin
            win_s = WIN_S2;
        end else begin
            win_s = WIN_S1;
        end
        s1_waitrequest = reset_n & collide_s & (win_s == WIN_S2);
        s2_waitrequest = reset_n & collide_s & (win_s == WIN_S1);
        s1_we_s   = s1_wr_s & ~s1_waitrequest & s1_inr_s;
        s2_we_s   = s2_wr_s & ~s2_waitrequest & s2_inr_s;
        oob_hit_s = ((s1_rd_s | (s1_wr_s & ~s1_waitrequest)) & ~s1_inr_s)
                  | ((s2_rd_s | (s2_wr_s & ~s2_waitrequest)) & ~s2_inr_s);
    end

    // Arbitration history, first read-valid stage and sticky range error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_lost_r <= 1'b0;
            s1_v1_r   <= 1'b0;
            s2_v1_r   <= 1'b0;
            err_oob_r <= 1'b0;
        end else begin
            if (en_s) begin
                s2_lost_r <= collide_s & (win_s == WIN_S1);
                s1_v1_r   <= s1_rd_s;
                s2_v1_r   <= s2_rd_s;
            end
            if (oob_hit_s) begin
                err_oob_r <= 1'b1;
            end
        end
    end

    assign err_oob = err_oob_r;

    onchip_mem_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .rst_n   (reset_n),
        .a_rd    (s1_rd_s),
        .a_we    (s1_we_s),
        .a_idx   (s1_address[IDX_W-1:0]),
        .a_be    (s1_byteenable),
        .a_wdata (s1_writedata),
        .a_zero  (~s1_inr_s),
        .a_q     (s1_q_s),
        .b_rd    (s2_rd_s),
        .b_we    (s2_we_s),
        .b_idx   (s2_address[IDX_W-1:0]),
        .b_be    (s2_byteenable),
        .b_wdata (s2_writedata),
        .b_zero  (~s2_inr_s),
        .b_q     (s2_q_s)
    );

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] s1_d2_r, s2_d2_r;
        logic                  s1_v2_r, s2_v2_r;

        // Second read stage, advancing only on enabled cycles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_d2_r <= '0;
                s2_d2_r <= '0;
                s1_v2_r <= 1'b0;
                s2_v2_r <= 1'b0;
            end else if (en_s) begin
                s1_d2_r <= s1_q_s;
                s2_d2_r <= s2_q_s;
                s1_v2_r <= s1_v1_r;
                s2_v2_r <= s2_v1_r;
            end
        end

        assign s1_readdata      = s1_d2_r;
        assign s2_readdata      = s2_d2_r;
        assign s1_readdatavalid = s1_v2_r & en_s;
        assign s2_readdatavalid = s2_v2_r & en_s;
    end else begin : g_lat1
        assign s1_readdata      = s1_q_s;
        assign s2_readdata      = s2_q_s;
        assign s1_readdatavalid = s1_v1_r & en_s;
        assign s2_readdatavalid = s2_v1_r & en_s;
    end

endmodule

// File: tb/tb_onchip_memory_dp_pipe.sv
// Directed scoreboard bench for onchip_memory_dp_pipe (DEPTH=1000, READ_LATENCY=2).
module tb_onchip_memory_dp_pipe;

    localparam int DW  = 32;
    localparam int AW  = 13;
    localparam int DEP = 1000;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset_n, clken, reset_req;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest, err_oob;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   ecnt   = 0;

    onchip_memory_dp_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
        .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    // Count enabled edges; the scoreboard keys read latency to this.
    always @(posedge clk) begin
        if (reset_n && clken && !reset_req) begin
            ecnt <= ecnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        logic have;
        if (!(clken && !reset_req)) begin
            chk($sformatf("s%0d_valid_frozen", p + 1), {31'd0, v}, 32'd0);
        end else if (v) begin
            have = (p == 0) ? (q1.size() != 0) : (q2.size() != 0);
            checks++;
            assert (have) else begin
                errors++;
                $error("FAIL s%0d_extra_valid observed=valid expected=no_valid", p + 1);
            end
            if (have) begin
                if (p == 0) e = q1.pop_front();
                else        e = q2.pop_front();
                chk($sformatf("s%0d_rdata", p + 1), d, e.data);
                chk($sformatf("s%0d_latency", p + 1), 32'(ecnt), 32'(e.due));
            end
        end
    endtask

    // Compare returned reads against the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, s1_readdatavalid, s1_readdata);
            mon(1, s2_readdatavalid, s2_readdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        if (p == 0) begin
            s1_chipselect = 1'b1; s1_write = 1'b1; s1_read = 1'b0;
            s1_address = a; s1_writedata = d; s1_byteenable = be;
        end else begin
            s2_chipselect = 1'b1; s2_write = 1'b1; s2_read = 1'b0;
            s2_address = a; s2_writedata = d; s2_byteenable = be;
        end
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [31:0] exp, input logic push);
        if (p == 0) begin
            s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = a;
            if (push) q1.push_back('{data: exp, due: ecnt + LAT});
        end else begin
            s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0; s2_address = a;
            if (push) q2.push_back('{data: exp, due: ecnt + LAT});
        end
    endtask

    initial begin
        reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
        s1_address = '0; s2_address = '0; s1_byteenable = 4'hF; s2_byteenable = 4'hF;
        s1_writedata = 32'd0; s2_writedata = 32'd0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s1_rdata", s1_readdata, 32'd0);
        chk("rst_s2_rdata", s2_readdata, 32'd0);
        chk("rst_s1_valid", {31'd0, s1_readdatavalid}, 32'd0);
        chk("rst_s2_valid", {31'd0, s2_readdatavalid}, 32'd0);
        chk("rst_s1_wait", {31'd0, s1_waitrequest}, 32'd0);
        chk("rst_err_oob", {31'd0, err_oob}, 32'd0);
        reset_n = 1'b1;

        // Write on s1, read back on s2 the next cycle.
        wr(0, 13'h10, 32'hDEADBEEF, 4'hF); tick(); idle();
        rd(1, 13'h10, 32'hDEADBEEF, 1'b1); tick(); idle();
        repeat (3) tick();

        // Byte enables, read-during-write old data, read+write treated as write.
        wr(1, 13'h20, 32'h11223344, 4'hF); tick(); idle();
        wr(0, 13'h20, 32'hAABBCCDD, 4'h5); rd(1, 13'h20, 32'h11223344, 1'b1); tick(); idle();
        rd(0, 13'h20, 32'h11BB33DD, 1'b1); tick(); idle();
        wr(1, 13'h40, 32'h00000055, 4'hF); s2_read = 1'b1; tick(); idle();
        rd(0, 13'h40, 32'h00000055, 1'b1); tick(); idle();
        repeat (3) tick();

        // Three-cycle write collision on one address.
        wr(0, 13'h30, 32'h1, 4'hF); wr(1, 13'h30, 32'h2, 4'hF); #1;
        chk("col1_s1_wait", {31'd0, s1_waitrequest}, 32'd0);
        chk("col1_s2_wait", {31'd0, s2_waitrequest}, 32'd1);
        tick(); #1;
        chk("col2_s1_wait", {31'd0, s1_waitrequest}, 32'd1);
        chk("col2_s2_wait", {31'd0, s2_waitrequest}, 32'd0);
        tick(); #1;
        chk("col3_s1_wait", {31'd0, s1_waitrequest}, 32'd0);
        chk("col3_s2_wait", {31'd0, s2_waitrequest}, 32'd1);
        tick(); idle();
        rd(0, 13'h30, 32'h1, 1'b1); tick(); idle();
        wr(0, 13'h31, 32'h7, 4'hF); wr(1, 13'h32, 32'h8, 4'hF); #1;
        chk("nocol_s1_wait", {31'd0, s1_waitrequest}, 32'd0);
        chk("nocol_s2_wait", {31'd0, s2_waitrequest}, 32'd0);
        tick(); idle();
        rd(0, 13'h31, 32'h7, 1'b1); rd(1, 13'h31, 32'h7, 1'b1); #1;
        chk("rd_s2_wait", {31'd0, s2_waitrequest}, 32'd0);
        tick(); idle();
        rd(1, 13'h32, 32'h8, 1'b1); tick(); idle();
        repeat (3) tick();

        // Back-to-back reads with a clock-enable gap.
        wr(0, 13'd0, 32'h0000A000, 4'hF); wr(1, 13'd1, 32'h0000A001, 4'hF); tick(); idle();
        wr(0, 13'd2, 32'h0000A002, 4'hF); wr(1, 13'd3, 32'h0000A003, 4'hF); tick(); idle();
        rd(0, 13'd0, 32'h0000A000, 1'b1); tick();
        rd(0, 13'd1, 32'h0000A001, 1'b1); tick();
        clken = 1'b0; rd(0, 13'd2, 32'h0000A002, 1'b0); tick();
        clken = 1'b1; rd(0, 13'd2, 32'h0000A002, 1'b1); tick();
        rd(0, 13'd3, 32'h0000A003, 1'b1); tick(); idle();
        repeat (4) tick();

        // Out-of-range accesses.
        chk("oob_pre", {31'd0, err_oob}, 32'd0);
        rd(0, 13'd1000, 32'd0, 1'b1); tick(); idle(); #1;
        chk("oob_set", {31'd0, err_oob}, 32'd1);
        wr(0, 13'd1000, 32'hFFFFFFFF, 4'hF); tick(); idle();
        wr(1, 13'd1024, 32'hBAD0BAD0, 4'hF); tick(); idle();
        rd(0, 13'd1000, 32'd0, 1'b1); rd(1, 13'd0, 32'h0000A000, 1'b1); tick(); idle();
        repeat (3) tick();
        chk("oob_sticky", {31'd0, err_oob}, 32'd1);

        // Reset with two reads in flight.
        rd(0, 13'h10, 32'd0, 1'b0); rd(1, 13'h20, 32'd0, 1'b0); tick(); idle();
        reset_n = 1'b0; #1;
        chk("arst_s1_rdata", s1_readdata, 32'd0);
        chk("arst_s2_rdata", s2_readdata, 32'd0);
        chk("arst_s1_valid", {31'd0, s1_readdatavalid}, 32'd0);
        chk("arst_s2_valid", {31'd0, s2_readdatavalid}, 32'd0);
        chk("arst_err_oob", {31'd0, err_oob}, 32'd0);
        q1.delete(); q2.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_err_oob", {31'd0, err_oob}, 32'd0);

        // reset_req blocks writes, reads and waitrequest.
        reset_req = 1'b1;
        wr(0, 13'h10, 32'h0, 4'hF); wr(1, 13'h10, 32'h0, 4'hF); #1;
        chk("rreq_s2_wait", {31'd0, s2_waitrequest}, 32'd0);
        tick(); idle();
        rd(0, 13'h20, 32'd0, 1'b0); tick(); idle();
        reset_req = 1'b0;
        rd(0, 13'h10, 32'hDEADBEEF, 1'b1); rd(1, 13'h20, 32'h11BB33DD, 1'b1); tick(); idle();
        repeat (4) tick();

        chk("drain_s1", 32'(q1.size()), 32'd0);
        chk("drain_s2", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
